// File: rtl/pipe_data_select_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_data_select_pkg
// Description : Shared CPU-pipeline definitions for the registered operand
//               selector. It holds the skid-buffer state encoding, the default
//               data width and the EX-stage forwarding channel indices.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_data_select_pkg;

  // Default width of every operand channel.
  localparam int DATA_W = 32;

  // Forwarding sources, used as channel numbers on in_data / in_sel.
  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;
  localparam int FWD_IMM   = 3;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pds_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_data_select_mux.sv
`default_nettype none
// ============================================================================
// Module      : pds_mux
// Description : Purely combinational NUM_IN:1 word selector.
//               When PIPE_DATA_SELECT_RANGE_CHECK_EN is defined, a select code
//               of NUM_IN or more yields an all-zero word and raises o_selErr.
//               Without the macro, no check logic exists and o_selErr is absent.
// Ports       : i_data   - NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//               i_sel    - binary channel select
//               o_word   - selected word
//               o_selErr - select code out of range (macro builds only)
// Revision    : 1.0 - initial release
// ============================================================================
module pds_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_word
`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
  ,
  output logic                    o_selErr
`endif
);

  // Every code the select field can carry gets a slot; slots beyond NUM_IN
  // are padded with zero so the index never leaves the array.
  localparam int c_SLOTS = 1 << SEL_W;

  logic [WIDTH-1:0] w_chan [c_SLOTS];

  genvar k;
  generate
    for (k = 0; k < c_SLOTS; k++) begin : g_chan
      if (k < NUM_IN) begin : g_present
        assign w_chan[k] = i_data[k*WIDTH +: WIDTH];
      end else begin : g_absent
        assign w_chan[k] = '0;
      end
    end
  endgenerate

`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
  // One extra bit so NUM_IN = 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] c_NUM_IN_EXT = (SEL_W+1)'(NUM_IN);

  assign o_selErr = ({1'b0, i_sel} >= c_NUM_IN_EXT);
  assign o_word   = o_selErr ? '0 : w_chan[i_sel];
`else
  assign o_word   = w_chan[i_sel];
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_data_select.sv
`default_nettype none
// ============================================================================
// Module      : pipe_data_select
// Description : Registered, flow-controlled N-way operand selector. The
//               selected channel is captured in a two-entry skid buffer
//               (MAIN drives out_data, SKID absorbs one extra word) and is
//               handed downstream with a valid/ready handshake. All outputs
//               are registered, so no combinational path runs from out_ready
//               to in_ready or from the inputs to the outputs.
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               flush     - synchronous discard of all buffered words
//               in_data   - NUM_IN packed channels of WIDTH bits
//               in_sel    - channel select, sampled with in_valid
//               in_valid  - upstream offers a word
//               in_ready  - block can accept (registered)
//               out_data  - head-of-buffer word (registered)
//               out_valid - out_data is valid (registered)
//               out_ready - downstream accepts out_data
//               sel_err   - sticky out-of-range select flag
// Config      : PIPE_DATA_SELECT_RANGE_CHECK_EN enables the range check and
//               the sel_err flag; otherwise sel_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_data_select
  import pipe_data_select_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [1:0] c_EMPTY = EMPTY;
  localparam logic [1:0] c_ONE   = ONE;
  localparam logic [1:0] c_FULL  = FULL;

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_word;
  logic             r_inReady;
  logic             r_outValid;
  logic             w_push;
  logic             w_pop;

  // --------------------------------------------------------------------------
  // Input-side selection
  // --------------------------------------------------------------------------
`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
  logic w_selErr;
`endif

  pds_mux #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .i_data   (in_data),
    .i_sel    (in_sel),
    .o_word   (w_word)
`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
    ,
    .o_selErr (w_selErr)
`endif
  );

  // --------------------------------------------------------------------------
  // Handshakes. r_inReady is low only in FULL, so a push never meets FULL.
  // --------------------------------------------------------------------------
  assign w_push = in_valid & r_inReady;
  assign w_pop  = r_outValid & out_ready;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_EMPTY: begin
        if (w_push) w_nextState = c_ONE;
      end
      c_ONE: begin
        if (w_push && !w_pop)      w_nextState = c_FULL;
        else if (!w_push && w_pop) w_nextState = c_EMPTY;
      end
      c_FULL: begin
        if (w_pop) w_nextState = c_ONE;
      end
      default: w_nextState = c_EMPTY;
    endcase
    if (flush) w_nextState = c_EMPTY;
  end

  // --------------------------------------------------------------------------
  // State, flags and the two data registers. The flags are derived from the
  // next state so they are registered yet exact in the following cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != c_FULL);
      r_outValid <= (w_nextState != c_EMPTY);
      // A flushed cycle stores nothing; the data registers simply hold.
      if (!flush) begin
        case (r_state)
          c_EMPTY: begin
            if (w_push) r_main <= w_word;
          end
          c_ONE: begin
            if (w_push) begin
              if (w_pop) r_main <= w_word;
              else       r_skid <= w_word;
            end
          end
          c_FULL: begin
            if (w_pop) r_main <= r_skid;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_main;

  // --------------------------------------------------------------------------
  // Sticky select-error flag
  // --------------------------------------------------------------------------
`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
  logic r_selErr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_selErr <= 1'b0;
    end else if (w_push && w_selErr && !flush) begin
      r_selErr <= 1'b1;
    end
  end

  assign sel_err = r_selErr;
`else
  assign sel_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_data_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_data_select
// Description : Self-checking bench for pipe_data_select. A queue-based
//               two-deep FIFO model predicts out_valid / in_ready / out_data
//               every cycle; directed sequences add literal expectations.
//               A second instance with NUM_IN = 3 covers the range check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_data_select;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [31:0]  chan [4];
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  // Second instance: three channels, so select code 3 is out of range.
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic         sel_err3;

  int errs   = 0;
  int checks = 0;
  bit cmpEn  = 0;
  int dutPops = 0;

  always #5 clk = ~clk;

  assign in_data  = {chan[3], chan[2], chan[1], chan[0]};
  assign in_data3 = {chan[2], chan[1], chan[0]};

  pipe_data_select #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  pipe_data_select #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Model: a FIFO of capacity two. A word enters when offered and room exists,
  // leaves when the head is offered and taken; flush and reset empty it.
  // --------------------------------------------------------------------------
  logic [31:0] mq[$];
  bit          mPush;
  bit          mPop;

  always @(posedge clk) begin
    if (out_valid && out_ready) dutPops++;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      mPush = in_valid && (mq.size() < 2);
      mPop  = out_ready && (mq.size() > 0);
      if (mPop)  void'(mq.pop_front());
      if (mPush) mq.push_back(chan[in_sel]);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      chk("sel_err",   {31'd0, sel_err},   32'd0);
    end
  end

  initial begin
    int p0;
    chan[0] = 32'h11111111;
    chan[1] = 32'h22222222;
    chan[2] = 32'h33333333;
    chan[3] = 32'h44444444;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_sel3 = 2'd0; out_ready3 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    cmpEn = 1;

    // Fill to FULL, then reset with handshakes and flush all active.
    in_valid = 1'b1; in_sel = 2'd0; step();
    in_sel = 2'd1; step();
    in_valid = 1'b0; step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1; step();
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'h00000000);
    chk("rst_sel_err",   {31'd0, sel_err},   32'd0);
    chk("rst_sel_err3",  {31'd0, sel_err3},  32'd0);

    // Single-cycle latency from EMPTY.
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd2; step();
    in_valid = 1'b0;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data",  out_data,           32'h33333333);
    step();
    chk("lat_drained",   {31'd0, out_valid}, 32'd0);

    // Back-pressure: third push refused, first two leave in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; step();
    chk("bp_ready_one",  {31'd0, in_ready},  32'd1);
    in_sel = 2'd1; step();
    chk("bp_ready_full", {31'd0, in_ready},  32'd0);
    in_sel = 2'd2; step();
    in_valid = 1'b0;
    chk("bp_head_hold",  out_data,           32'h11111111);
    out_ready = 1'b1; step();
    chk("bp_second",     out_data,           32'h22222222);
    chk("bp_second_v",   {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_no_third",   {31'd0, out_valid}, 32'd0);

    // Streaming: 100 back-to-back pushes with random selects.
    p0 = dutPops;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_sel = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_pops", dutPops - p0, 32'd100);

    // Flush in FULL while an input is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; step();
    in_sel = 2'd1; step();
    flush = 1'b1; in_sel = 2'd3; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd2; step();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 32'h33333333);
    step();
    chk("post_flush_empty", {31'd0, out_valid}, 32'd0);

    // Out-of-range select on the three-channel instance.
    in_valid3 = 1'b1; in_sel3 = 2'd3; step();
    in_valid3 = 1'b0;
    chk("oor_out_valid", {31'd0, out_valid3}, 32'd1);
`ifdef PIPE_DATA_SELECT_RANGE_CHECK_EN
    chk("oor_word",      out_data3,           32'h00000000);
    chk("oor_sel_err",   {31'd0, sel_err3},   32'd1);
    step(); step(); step();
    chk("oor_sticky",    {31'd0, sel_err3},   32'd1);
`else
    chk("oor_sel_err",   {31'd0, sel_err3},   32'd0);
    step(); step(); step();
    chk("oor_sticky",    {31'd0, sel_err3},   32'd0);
`endif
    // In-range push after the error leaves the flag untouched.
    out_ready3 = 1'b1; in_valid3 = 1'b1; in_sel3 = 2'd1; step();
    in_valid3 = 1'b0;
    chk("oor_next_data", out_data3, 32'h22222222);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk("oor_rst_clear", {31'd0, sel_err3},  32'd0);
    chk("oor_rst_data",  out_data3,          32'h00000000);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
